ram_access_arbiter: RTL and testbench

- Shares the single-port 32x32 user RAM macro between two requesters:
  - port 0: the host/Wishbone register side.
  - port 1: the user design logic.
- Sequences every access through a fixed 4-cycle FSM.
- Arbitrates round-robin or fixed-priority, with a host lock that reserves the RAM for port 0.
- Exposes per-port grant counters and status for Wishbone readback.

---
 rtl/ram_access_arbiter_if.sv | 24 ++
 rtl/ram_access_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// rtl/ram_access_arbiter_if.sv - requester access port bundle for the RAM arbiter
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    // requester side: drives the request and payload, receives completion
    modport master (
        output req, we, addr, wdata,
        input  done, rdata
    );

    // arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output done, rdata
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port arbiter sequencing accesses to a single-port RAM
module ram_access_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIORITY = 0,
    parameter int CNT_W          = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    ram_access_arbiter_if.slave r0,
    ram_access_arbiter_if.slave r1,
    input  logic                lock0,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy,
    output logic                owner,
    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                busy_q, busy_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                acc_we_q, acc_we_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;
    logic                r0_done_q, r0_done_d;
    logic                r1_done_q, r1_done_d;
    logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;

    logic elig0;
    logic elig1;
    logic win;

    // eligibility and winner selection; lock0 hides port 1 from the arbiter
    always_comb begin
        elig0 = r0.req;
        elig1 = r1.req && !lock0;
        win   = 1'b0;
        if (elig0 && elig1) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            win = elig1;
        end
    end

    // next-state and next-output computation for the 4-cycle access sequence
    always_comb begin
        state_d      = state_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        busy_d       = busy_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        acc_we_d     = acc_we_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        r0_done_d    = 1'b0;
        r1_done_d    = 1'b0;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    ram_en_d     = 1'b1;
                    ram_we_d     = win ? r1.we : r0.we;
                    acc_we_d     = win ? r1.we : r0.we;
                    ram_addr_d   = win ? r1.addr : r0.addr;
                    ram_wdata_d  = win ? r1.wdata : r0.wdata;
                    owner_d      = win;
                    last_grant_d = win;
                    busy_d       = 1'b1;
                    state_d      = S_ACCESS;
                    if (win) begin
                        if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // write accesses leave the requester's last read data untouched
                if (!acc_we_q) begin
                    if (owner_q) r1_rdata_d = ram_rdata;
                    else         r0_rdata_d = ram_rdata;
                end
                if (owner_q) r1_done_d = 1'b1;
                else         r0_done_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // state and output registers; reset aborts any access in flight
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            acc_we_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            r0_done_q    <= 1'b0;
            r1_done_q    <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            acc_we_q     <= acc_we_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            r0_done_q    <= r0_done_d;
            r1_done_q    <= r1_done_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
    assign r0.done   = r0_done_q;
    assign r1.done   = r1_done_q;
    assign r0.rdata  = r0_rdata_q;
    assign r1.rdata  = r1_rdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - directed self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

    logic clk;
    logic rst;
    logic lock0_a;
    logic lock0_b;

    int n_checks;
    int n_errors;

    // DUT A: round-robin, 16-bit counters
    ram_access_arbiter_if #(.ADDR_W(5), .DATA_W(32)) ia0 ();
    ram_access_arbiter_if #(.ADDR_W(5), .DATA_W(32)) ia1 ();
    logic        a_ram_en, a_ram_we, a_busy, a_owner;
    logic [4:0]  a_ram_addr;
    logic [31:0] a_ram_wdata, a_ram_rdata;
    logic [15:0] a_cnt0, a_cnt1;

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIORITY(0), .CNT_W(16)) dut_a (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .r0        (ia0.slave),
        .r1        (ia1.slave),
        .lock0     (lock0_a),
        .ram_en    (a_ram_en),
        .ram_we    (a_ram_we),
        .ram_addr  (a_ram_addr),
        .ram_wdata (a_ram_wdata),
        .ram_rdata (a_ram_rdata),
        .busy      (a_busy),
        .owner     (a_owner),
        .cnt0      (a_cnt0),
        .cnt1      (a_cnt1)
    );

    // DUT B: fixed priority, 4-bit counters
    ram_access_arbiter_if #(.ADDR_W(5), .DATA_W(32)) ib0 ();
    ram_access_arbiter_if #(.ADDR_W(5), .DATA_W(32)) ib1 ();
    logic        b_ram_en, b_ram_we, b_busy, b_owner;
    logic [4:0]  b_ram_addr;
    logic [31:0] b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_cnt0, b_cnt1;

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIORITY(1), .CNT_W(4)) dut_b (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .r0        (ib0.slave),
        .r1        (ib1.slave),
        .lock0     (lock0_b),
        .ram_en    (b_ram_en),
        .ram_we    (b_ram_we),
        .ram_addr  (b_ram_addr),
        .ram_wdata (b_ram_wdata),
        .ram_rdata (b_ram_rdata),
        .busy      (b_busy),
        .owner     (b_owner),
        .cnt0      (b_cnt0),
        .cnt1      (b_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: registered read, write on enable
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    always @(posedge clk) begin
        if (pre_we) mem_a[pre_addr] <= pre_data;
        else if (a_ram_en) begin
            if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
            else          a_ram_rdata <= mem_a[a_ram_addr];
        end
    end

    always @(posedge clk) begin
        if (b_ram_en) begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
            else          b_ram_rdata <= mem_b[b_ram_addr];
        end
    end

    // grant and protocol monitors
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int ga_port[$];
    int ga_cyc[$];
    int gb_port[$];
    int en_long;
    int done_overlap;
    logic a_en_prev, b_en_prev;

    always @(negedge clk) begin
        if (a_ram_en) begin
            ga_port.push_back(int'(a_owner));
            ga_cyc.push_back(cyc);
        end
        if (b_ram_en) gb_port.push_back(int'(b_owner));
        if (a_ram_en && a_en_prev) en_long++;
        if (b_ram_en && b_en_prev) en_long++;
        if (ia0.done && ia1.done) done_overlap++;
        if (ib0.done && ib1.done) done_overlap++;
        a_en_prev = a_ram_en;
        b_en_prev = b_ram_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input int p, input logic req, input logic we,
                         input logic [4:0] addr, input logic [31:0] wdata);
        case ({d[0], p[0]})
            2'b00: begin ia0.req = req; ia0.we = we; ia0.addr = addr; ia0.wdata = wdata; end
            2'b01: begin ia1.req = req; ia1.we = we; ia1.addr = addr; ia1.wdata = wdata; end
            2'b10: begin ib0.req = req; ib0.we = we; ib0.addr = addr; ib0.wdata = wdata; end
            default: begin ib1.req = req; ib1.we = we; ib1.addr = addr; ib1.wdata = wdata; end
        endcase
    endtask

    function automatic logic get_done(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return ia0.done;
            2'b01:   return ia1.done;
            2'b10:   return ib0.done;
            default: return ib1.done;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return ia0.rdata;
            2'b01:   return ia1.rdata;
            2'b10:   return ib0.rdata;
            default: return ib1.rdata;
        endcase
    endfunction

    // full access from one requester: raise req, wait for done, drop req, settle in IDLE
    task automatic access(input int d, input int p, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        bit seen;
        seen = 1'b0;
        drive(d, p, 1'b1, we, addr, wdata);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (get_done(d, p)) seen = 1'b1;
        end
        check("access_done_seen", 64'(seen), 64'd1);
        rdata = get_rdata(d, p);
        drive(d, p, 1'b0, we, addr, wdata);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int base;
        int ndone;
        int n0;
        bit seen;

        n_checks = 0;
        n_errors = 0;
        en_long = 0;
        done_overlap = 0;
        a_en_prev = 1'b0;
        b_en_prev = 1'b0;
        cyc = 0;
        rst = 1'b1;
        lock0_a = 1'b0;
        lock0_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            drive(0, p, 1'b0, 1'b0, 5'd0, 32'd0);
            drive(1, p, 1'b0, 1'b0, 5'd0, 32'd0);
        end
        pre_we = 1'b1;
        pre_addr = 5'd5;
        pre_data = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        pre_we = 1'b0;
        rst = 1'b0;

        // reset state
        check("rst_ram_en", 64'(a_ram_en), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_owner", 64'(a_owner), 64'd0);
        check("rst_cnt", 64'({a_cnt0, a_cnt1}), 64'd0);
        check("rst_done_rdata", 64'({ia0.done, ia1.done, ia0.rdata}), 64'd0);

        // single read of preloaded word
        drive(0, 0, 1'b1, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        check("rd_c1_en_we_addr", 64'({a_ram_en, a_ram_we, a_ram_addr}), 64'({1'b1, 1'b0, 5'd5}));
        check("rd_c1_busy_owner", 64'({a_busy, a_owner}), 64'b10);
        check("rd_c1_cnt0", 64'(a_cnt0), 64'd1);
        @(negedge clk);
        check("rd_c2_en_busy_done", 64'({a_ram_en, a_busy, ia0.done}), 64'b010);
        @(negedge clk);
        check("rd_c3_busy_done", 64'({a_busy, ia0.done, ia1.done}), 64'b110);
        check("rd_c3_rdata", 64'(ia0.rdata), 64'hDEADBEEF);
        drive(0, 0, 1'b0, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        check("rd_c4_idle", 64'({a_busy, ia0.done, a_ram_en}), 64'd0);

        // write then read on port 1
        access(0, 1, 1'b1, 5'd31, 32'h12345678, rd);
        check("wr_rdata_hold", 64'(rd), 64'd0);
        check("wr_mem31", 64'(mem_a[31]), 64'h12345678);
        access(0, 1, 1'b0, 5'd31, 32'd0, rd);
        check("rd_back", 64'(rd), 64'h12345678);
        check("cnt1_after_wr_rd", 64'(a_cnt1), 64'd2);

        // round-robin contention, last grant was port 1
        base = ga_port.size();
        ndone = 0;
        drive(0, 0, 1'b1, 1'b0, 5'd1, 32'd0);
        drive(0, 1, 1'b1, 1'b0, 5'd2, 32'd0);
        for (int n = 0; n < 40 && ndone < 4; n++) begin
            @(negedge clk);
            if (ia0.done || ia1.done) ndone++;
        end
        drive(0, 0, 1'b0, 1'b0, 5'd1, 32'd0);
        drive(0, 1, 1'b0, 1'b0, 5'd2, 32'd0);
        @(negedge clk);
        check("rr_done_count", 64'(ndone), 64'd4);
        check("rr_grant_count", 64'(ga_port.size() - base), 64'd4);
        if (ga_port.size() - base == 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 64'(ga_port[base + i]), 64'(i % 2));
            for (int i = 0; i < 3; i++) check("rr_spacing", 64'(ga_cyc[base + i + 1] - ga_cyc[base + i]), 64'd4);
        end
        check("rr_cnts", 64'({a_cnt0, a_cnt1}), 64'({16'd3, 16'd4}));

        // lock0 holds off port 1
        lock0_a = 1'b1;
        drive(0, 1, 1'b1, 1'b0, 5'd3, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ia1.done || a_ram_en) seen = 1'b1;
        end
        check("lock_no_r1", 64'(seen), 64'd0);
        check("lock_cnt1", 64'(a_cnt1), 64'd4);
        lock0_a = 1'b0;
        @(negedge clk);
        check("unlock_grant", 64'({a_ram_en, a_owner}), 64'b11);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (ia1.done) seen = 1'b1;
        end
        check("unlock_done", 64'(seen), 64'd1);
        drive(0, 1, 1'b0, 1'b0, 5'd3, 32'd0);
        @(negedge clk);

        // lock0 raised mid-access does not abort port 1
        drive(0, 1, 1'b1, 1'b0, 5'd31, 32'd0);
        @(negedge clk);
        check("midlock_grant", 64'({a_ram_en, a_owner}), 64'b11);
        lock0_a = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (ia1.done) seen = 1'b1;
        end
        check("midlock_done", 64'(seen), 64'd1);
        check("midlock_rdata", 64'(ia1.rdata), 64'h12345678);
        drive(0, 1, 1'b0, 1'b0, 5'd31, 32'd0);
        lock0_a = 1'b0;
        @(negedge clk);
        check("midlock_cnt1", 64'(a_cnt1), 64'd6);

        // reset asserted during ACCESS
        drive(0, 0, 1'b1, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        check("rst_mid_pre_en", 64'(a_ram_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_en_busy", 64'({a_ram_en, a_busy, a_owner}), 64'd0);
        check("rst_mid_cnts", 64'({a_cnt0, a_cnt1}), 64'd0);
        drive(0, 0, 1'b0, 1'b0, 5'd5, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ia0.done || ia1.done || a_ram_en) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);

        // fixed priority on DUT B: port 0 wins every tie
        base = gb_port.size();
        n0 = 0;
        seen = 1'b0;
        drive(1, 0, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1, 1, 1'b1, 1'b0, 5'd0, 32'd0);
        for (int n = 0; n < 40 && n0 < 3; n++) begin
            @(negedge clk);
            if (ib0.done) n0++;
            if (ib1.done) seen = 1'b1;
        end
        drive(1, 0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("fp_r0_wins", 64'({n0[7:0], 7'd0, seen}), 64'({8'd3, 8'd0}));
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (ib1.done) seen = 1'b1;
        end
        check("fp_r1_after_release", 64'(seen), 64'd1);
        drive(1, 1, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("fp_grant_count", 64'(gb_port.size() - base), 64'd4);
        if (gb_port.size() - base == 4) begin
            for (int i = 0; i < 4; i++) check("fp_order", 64'(gb_port[base + i]), 64'(i == 3 ? 1 : 0));
        end
        check("fp_cnts", 64'({b_cnt0, b_cnt1}), 64'({4'd3, 4'd1}));

        // saturation of the 4-bit counter
        repeat (12) access(1, 0, 1'b0, 5'd7, 32'd0, rd);
        check("sat_reach_15", 64'(b_cnt0), 64'd15);
        repeat (8) access(1, 0, 1'b0, 5'd7, 32'd0, rd);
        check("sat_hold_15", 64'(b_cnt0), 64'd15);
        check("sat_cnt1", 64'(b_cnt1), 64'd1);

        check("ram_en_single_cycle", 64'(en_long), 64'd0);
        check("done_no_overlap", 64'(done_overlap), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
